// File: rtl/cmd_reg_parser.sv
// Byte-oriented command parser for a bank of argument registers.
// "P<idx><ARG_W binary digits>" writes a register, "Q<idx>" reads it back
// least-significant byte first. Replies are "*" on success and "!" on error.
// Handshake: txDataWr is a single-cycle strobe that carries txData. A strobe is
// only issued when txBusy was low in the deciding cycle, at most one byte per
// strobe, and never on two consecutive cycles. NewCmd is a single-cycle strobe
// qualifying Cmd; there is no back-pressure on the receive side.
module cmd_reg_parser #(
  parameter int NUM_REGS = 4,
  parameter int ARG_W    = 10,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                Cmd,
  input  logic                      NewCmd,
  input  logic                      txBusy,
  output logic [NUM_REGS*ARG_W-1:0] regOut,
  output logic [NUM_REGS-1:0]       regStrobe,
  output logic [7:0]                txData,
  output logic                      txDataWr,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BCNT_W = $clog2(ARG_W + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int NBYTES = (ARG_W + 7) / 8;

  localparam logic [7:0] CH_P      = 8'h50;
  localparam logic [7:0] CH_Q      = 8'h51;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_1      = 8'h31;
  localparam logic [7:0] CH_ACK    = 8'h2A;
  localparam logic [7:0] CH_ERR    = 8'h21;
  localparam logic [7:0] IDX_LIMIT = 8'(8'h30 + NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_IDX,
    S_W_BITS,
    S_COMMIT,
    S_R_IDX,
    S_R_SEND,
    S_ACK,
    S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ARG_W-1:0]          shadow_q, shadow_d;
  logic [BCNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [NUM_REGS*ARG_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       strobe_q, strobe_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      tx_wr_q, tx_wr_d;

  logic        can_tx;
  logic        is_abort;
  logic        in_timed;
  logic        timed_out;
  logic        idx_ok;
  logic [15:0] rd_val;
  logic [7:0]  rd_byte;

  // A fresh byte may go out only if the UART is idle and no strobe is on the wire now.
  assign can_tx    = !txBusy && !tx_wr_q;
  assign is_abort  = NewCmd && (Cmd == CH_R);
  assign in_timed  = (state_q == S_W_IDX) || (state_q == S_W_BITS) || (state_q == S_R_IDX);
  assign timed_out = in_timed && !NewCmd && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign idx_ok    = (Cmd >= CH_0) && (Cmd < IDX_LIMIT);

  // Zero-extend the selected committed register and pick the byte being sent.
  always_comb begin
    rd_val = '0;
    rd_val[ARG_W-1:0] = regs_q[idx_q*ARG_W +: ARG_W];
    rd_byte = byte_cnt_q ? rd_val[15:8] : rd_val[7:0];
  end

  // Next-state and datapath decisions; an "R" byte overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = '0;
    regs_d     = regs_q;
    strobe_d   = '0;
    tx_data_d  = '0;
    tx_wr_d    = 1'b0;

    if (in_timed) begin
      to_cnt_d = NewCmd ? '0 : to_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (NewCmd && (Cmd == CH_P)) begin
          state_d   = S_W_IDX;
          shadow_d  = '0;
          bit_cnt_d = '0;
        end else if (NewCmd && (Cmd == CH_Q)) begin
          state_d    = S_R_IDX;
          byte_cnt_d = 1'b0;
        end
      end
      S_W_IDX: begin
        if (NewCmd) begin
          if (idx_ok) begin
            idx_d   = IDX_W'(Cmd - CH_0);
            state_d = S_W_BITS;
          end else begin
            state_d = S_ERR;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_W_BITS: begin
        if (NewCmd) begin
          if ((Cmd == CH_0) || (Cmd == CH_1)) begin
            shadow_d  = ARG_W'({shadow_q, Cmd[0]});
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BCNT_W'(ARG_W - 1)) begin
              state_d = S_COMMIT;
            end
          end else begin
            state_d = S_ERR;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_COMMIT: begin
        regs_d[idx_q*ARG_W +: ARG_W] = shadow_q;
        strobe_d[idx_q]              = 1'b1;
        state_d                      = S_ACK;
      end
      S_R_IDX: begin
        if (NewCmd) begin
          if (idx_ok) begin
            idx_d      = IDX_W'(Cmd - CH_0);
            byte_cnt_d = 1'b0;
            state_d    = S_R_SEND;
          end else begin
            state_d = S_ERR;
          end
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end
      S_R_SEND: begin
        if (can_tx) begin
          tx_wr_d   = 1'b1;
          tx_data_d = rd_byte;
          if (byte_cnt_q == 1'(NBYTES - 1)) begin
            state_d = S_ACK;
          end else begin
            byte_cnt_d = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (can_tx) begin
          tx_wr_d   = 1'b1;
          tx_data_d = CH_ACK;
          state_d   = S_IDLE;
        end
      end
      S_ERR: begin
        if (can_tx) begin
          tx_wr_d   = 1'b1;
          tx_data_d = CH_ERR;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: back to idle, scratch state cleared, committed registers untouched.
    if (is_abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      shadow_d   = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = 1'b0;
      to_cnt_d   = '0;
      regs_d     = regs_q;
      strobe_d   = '0;
      tx_data_d  = '0;
      tx_wr_d    = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= 1'b0;
      to_cnt_q   <= '0;
      regs_q     <= '0;
      strobe_q   <= '0;
      tx_data_q  <= '0;
      tx_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      regs_q     <= regs_d;
      strobe_q   <= strobe_d;
      tx_data_q  <= tx_data_d;
      tx_wr_q    <= tx_wr_d;
    end
  end

  assign regOut    = regs_q;
  assign regStrobe = strobe_q;
  assign txData    = tx_data_q;
  assign txDataWr  = tx_wr_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/cmd_reg_parser.md
CMD_REG_PARSER -- requirements
Module: cmd_reg_parser

Interface
REQ-001 Parameter NUM_REGS, default 4, number of settable argument registers (legal 1..10).
REQ-002 Parameter ARG_W, default 10, width of each argument register in bits (legal 1..16).
REQ-003 Parameter TIMEOUT, default 1000000, idle cycles allowed between bytes of one command (legal >= 2).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 Cmd  input  8  received UART byte, valid when NewCmd=1.
REQ-007 NewCmd  input  1  one-cycle strobe per received byte.
REQ-008 txBusy  input  1  UART transmitter busy; no write issued while high.
REQ-009 regOut  output  NUM_REGS*ARG_W  flattened registers; register i at bits [i*ARG_W +: ARG_W].
REQ-010 regStrobe  output  NUM_REGS  one-hot pulse, one cycle, on update of register i.
REQ-011 txData  output  8  byte to transmit.
REQ-012 txDataWr  output  1  one-cycle transmit strobe.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, W_IDX, W_BITS, COMMIT, R_IDX, R_SEND, ACK, ERR.
REQ-015 IDLE: "P" -> W_IDX; "Q" -> R_IDX; any other byte ignored, no response.
REQ-016 W_IDX/R_IDX: byte "0".."(NUM_REGS-1)" latched as index -> W_BITS/R_SEND; any other byte -> ERR.
REQ-017 W_BITS: "0"/"1" shifted MSB-first into shadow register, bit counter incremented; any other byte -> ERR.
REQ-018 Exactly ARG_W digits accepted; on the ARG_W-th digit -> COMMIT next cycle.
REQ-019 COMMIT: shadow copied to register[index] and regStrobe[index]=1 in the same cycle; -> ACK; registers never partially updated.
REQ-020 R_SEND: CEIL(ARG_W/8) bytes sent, least-significant byte first, unused upper bits zero; -> ACK after last byte.
REQ-021 ACK sends "*" (0x2A), ERR sends "!" (0x21), then -> IDLE.
REQ-022 Transmit rule: txDataWr pulses one cycle only when txBusy=0; state holds while txBusy=1; one byte per pulse; txData=0 when txDataWr=0.
REQ-023 Byte after txDataWr pulse waits at least one cycle before next pulse (txBusy sampled fresh).
REQ-024 Timeout counter cleared on every NewCmd and on entry to W_IDX/R_IDX; counting TIMEOUT cycles without NewCmd in W_IDX, W_BITS or R_IDX -> ERR.
REQ-025 "R" (0x52) with NewCmd in any state -> IDLE next cycle, shadow and counters cleared, pending transmit cancelled, registers unchanged, no response.
REQ-026 "R" in IDLE is a no-op; "R" has priority over timeout and every other transition.
REQ-027 NewCmd bytes other than "R" arriving in COMMIT, R_SEND, ACK or ERR are dropped.
REQ-028 Writing register i while reading it is impossible (single command path); readback returns committed value only.

Reset
REQ-029 rst=1: state IDLE, all registers 0, regStrobe 0, txData 0, txDataWr 0, busy 0, shadow/counters/timeout 0.
REQ-030 rst has priority over NewCmd and "R"; rst mid-transfer aborts with no further transmit bytes.

Verification
REQ-031 Defaults, txBusy=0: "P","2","1111111101" -> regOut[2]=0x3FD, regStrobe=4'b0100 one cycle, tx "*".
REQ-032 After REQ-031: "Q","2" -> tx 0xFD, 0x03, "*" in order, regOut unchanged.
REQ-033 "P","1","10x" -> tx "!", regOut[1] unchanged, regStrobe never asserted; "P","7" -> tx "!".
REQ-034 "P","0","1" then no bytes for TIMEOUT cycles -> tx "!", state IDLE, regOut[0] unchanged.
REQ-035 txBusy=1 held 50 cycles during ACK -> txDataWr stays 0, "*" sent one cycle after txBusy falls.
REQ-036 "P","3","10101" then "R" -> no tx, IDLE, regOut[3] unchanged; subsequent full "P" command still works.
